// File: rtl/prach_pkg.sv
// Shared types and phase arithmetic for the PRACH NCO scheduler.
package prach_pkg;

   localparam int PHASE_W   = 11;
   localparam int PHASE_MOD = 1536;
   localparam int CHN_W     = 8;

   typedef logic [PHASE_W-1:0] phase_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } nco_sched_state_e;

   // Both operands must already be below PHASE_MOD, so one subtraction is enough.
   function automatic phase_t phase_add(input phase_t a, input phase_t b);
      logic [PHASE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= (PHASE_W+1)'(PHASE_MOD)) begin
         sum = sum - (PHASE_W+1)'(PHASE_MOD);
      end
      return sum[PHASE_W-1:0];
   endfunction

endpackage

// File: rtl/prach_nco_sched_if.sv
// Sample, configuration and phase-output signals of the PRACH NCO scheduler.
interface prach_nco_sched_if;
   import prach_pkg::*;

   logic             din_dv;
   logic [CHN_W-1:0] din_chn;
   logic             sync_in;
   logic             cfg_wr;
   logic [2:0]       cfg_chn;
   phase_t           cfg_fcw;
   logic             cfg_commit;
   logic             cfg_err;
   logic             cfg_pend;
   phase_t           phase;
   logic [CHN_W-1:0] phase_chn;
   logic             phase_dv;
   logic             sync_out;

   modport master (
      output din_dv, din_chn, sync_in, cfg_wr, cfg_chn, cfg_fcw, cfg_commit,
      input  cfg_err, cfg_pend, phase, phase_chn, phase_dv, sync_out
   );

   modport slave (
      input  din_dv, din_chn, sync_in, cfg_wr, cfg_chn, cfg_fcw, cfg_commit,
      output cfg_err, cfg_pend, phase, phase_chn, phase_dv, sync_out
   );

endinterface

// File: rtl/prach_fcw_bank.sv
// Shadow/active FCW banks; shadow is copied to active only on a sync after a commit.
// fcw_eff_o is the active bank as it will be after this cycle (equals active outside sync cycles).
module prach_fcw_bank
   import prach_pkg::*;
#(
   parameter int     NUM_CHN = 4,
   parameter phase_t FCW_RST = phase_t'(432)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_wr_i,
   input  logic [2:0]                 cfg_chn_i,
   input  phase_t                     cfg_fcw_i,
   input  logic                       cfg_commit_i,
   input  logic                       sync_i,
   output phase_t [NUM_CHN-1:0]       fcw_eff_o,
   output logic                       cfg_err_o,
   output logic                       cfg_pend_o
);

   phase_t [NUM_CHN-1:0] shadow_q, shadow_d;
   phase_t [NUM_CHN-1:0] active_q, active_d;
   logic                 pend_q, pend_d;
   logic                 err_q, err_d;
   logic                 wr_legal;

   always_comb begin
      wr_legal = (cfg_fcw_i < PHASE_W'(PHASE_MOD)) && ({1'b0, cfg_chn_i} < 4'(NUM_CHN));
      shadow_d = shadow_q;
      for (int i = 0; i < NUM_CHN; i++) begin
         if (cfg_wr_i && wr_legal && (cfg_chn_i == 3'(i))) begin
            shadow_d[i] = cfg_fcw_i;
         end
      end
      // A write in the sync cycle itself is included in the copy.
      active_d = (sync_i && (pend_q || cfg_commit_i)) ? shadow_d : active_q;
      pend_d   = sync_i ? 1'b0 : (pend_q || cfg_commit_i);
      err_d    = err_q || (cfg_wr_i && !wr_legal);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= {NUM_CHN{FCW_RST}};
         active_q <= {NUM_CHN{FCW_RST}};
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
      end
   end

   assign fcw_eff_o  = active_d;
   assign cfg_err_o  = err_q;
   assign cfg_pend_o = pend_q;

endmodule

// File: rtl/prach_nco_sched.sv
// Per-channel phase accumulators for the PRACH NCO with a fixed 2-clock output pipe.
//   state | meaning
//   IDLE  | waiting for first symbol boundary; samples dropped
//   RUN   | accumulating and emitting one phase per valid sample
module prach_nco_sched
   import prach_pkg::*;
#(
   parameter int     NUM_CHN = 4,
   parameter phase_t FCW_RST = phase_t'(432)
) (
   input  logic              clk,
   input  logic              rst,
   prach_nco_sched_if.slave  bus
);

   nco_sched_state_e     state_q, state_d;
   phase_t [NUM_CHN-1:0] acc_q, acc_d;
   phase_t [NUM_CHN-1:0] fcw_eff;
   logic                 smp_ok;
   phase_t               smp_phase;

   logic                 dv1_q, sync1_q, dv2_q, sync2_q;
   logic [CHN_W-1:0]     chn1_q, chn2_q;
   phase_t               ph1_q, ph2_q;
   logic                 cfg_err, cfg_pend;

   prach_fcw_bank #(
      .NUM_CHN (NUM_CHN),
      .FCW_RST (FCW_RST)
   ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .cfg_wr_i     (bus.cfg_wr),
      .cfg_chn_i    (bus.cfg_chn),
      .cfg_fcw_i    (bus.cfg_fcw),
      .cfg_commit_i (bus.cfg_commit),
      .sync_i       (bus.sync_in),
      .fcw_eff_o    (fcw_eff),
      .cfg_err_o    (cfg_err),
      .cfg_pend_o   (cfg_pend)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      smp_phase = '0;
      smp_ok    = (state_q == RUN) && bus.din_dv && (bus.din_chn < CHN_W'(NUM_CHN));
      if (bus.sync_in) begin
         state_d = RUN;
         acc_d   = '0;
      end
      for (int i = 0; i < NUM_CHN; i++) begin
         if (smp_ok && (bus.din_chn == CHN_W'(i))) begin
            // On a sync the accumulator restarts from zero, so the next phase is one FCW.
            smp_phase = bus.sync_in ? '0 : acc_q[i];
            acc_d[i]  = bus.sync_in ? fcw_eff[i] : phase_add(acc_q[i], fcw_eff[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         dv1_q   <= 1'b0;
         chn1_q  <= '0;
         ph1_q   <= '0;
         sync1_q <= 1'b0;
         dv2_q   <= 1'b0;
         chn2_q  <= '0;
         ph2_q   <= '0;
         sync2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dv1_q   <= smp_ok;
         chn1_q  <= smp_ok ? bus.din_chn : '0;
         ph1_q   <= smp_phase;
         sync1_q <= bus.sync_in;
         dv2_q   <= dv1_q;
         chn2_q  <= chn1_q;
         ph2_q   <= ph1_q;
         sync2_q <= sync1_q;
      end
   end

   assign bus.phase     = ph2_q;
   assign bus.phase_chn = chn2_q;
   assign bus.phase_dv  = dv2_q;
   assign bus.sync_out  = sync2_q;
   assign bus.cfg_err   = cfg_err;
   assign bus.cfg_pend  = cfg_pend;

endmodule
